// File: rtl/gate_bist_pkg.sv
// Shared types and helpers for the universal gate BIST sequencer.
package gate_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_APPLY     = 3'd1,
        S_SETTLE    = 3'd2,
        S_CHECK_END = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam int         NUM_PAT = 4;
    localparam logic [7:0] ERR_MAX = 8'hFF;

    // Golden response of the gate pair: {nand, nor}.
    function automatic logic [1:0] exp_nand_nor(input logic a, input logic b);
        return {~(a & b), ~(a | b)};
    endfunction

endpackage

// File: rtl/universal_gate_bist_if.sv
// Control/status bundle between a host and the gate BIST sequencer.
interface universal_gate_bist_if;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [7:0] err_cnt;

    modport master (output start, abort,
                    input  busy, done, pass, fail_mask, err_cnt);
    modport slave  (input  start, abort,
                    output busy, done, pass, fail_mask, err_cnt);
endinterface

// File: rtl/bist_settle_timer.sv
// Loadable down-counter; expire marks the last cycle of a settle window.
module bist_settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);
    logic [CNT_W-1:0] cnt;

    // Load the window length, then count down while enabled, stopping at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/universal_gate_bist.sv
// BIST sequencer around a NAND/NOR gate pair: sweeps {a,b}, checks outputs,
// and reports a sticky per-pattern fail mask, saturating error count and pass.
module universal_gate_bist
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int SWEEPS        = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    universal_gate_bist_if.slave ctl,
    input  logic                y_nand,
    input  logic                y_nor,
    output logic                a_out,
    output logic                b_out
);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LAST_SWEEP  = 8'(SWEEPS - 1);
    localparam logic [1:0] LAST_PAT    = 2'(NUM_PAT - 1);

    state_t     state, state_nxt;
    logic [1:0] pat;
    logic [7:0] sweep;
    logic       timer_load, timer_en, expire;
    logic       start_run, abort_run, sample, mismatch;
    logic       pass_q;
    logic [3:0] fail_mask_q;
    logic [7:0] err_cnt_q;

    assign timer_load = (state == S_APPLY);
    assign timer_en   = (state == S_SETTLE);

    bist_settle_timer #(.CNT_W(4)) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .en       (timer_en),
        .expire   (expire)
    );

    // Compare only against the registered stimulus, never the live pattern index.
    assign mismatch = ({y_nand, y_nor} != exp_nand_nor(a_out, b_out));
    assign sample   = expire && !abort_run;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and run strobes; abort overrides everything outside IDLE.
    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        abort_run = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctl.start && !ctl.abort) begin
                    start_run = 1'b1;
                    state_nxt = S_APPLY;
                end
            end
            S_APPLY:  state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (expire) begin
                    if ((pat != LAST_PAT) || (sweep != LAST_SWEEP)) state_nxt = S_APPLY;
                    else                                            state_nxt = S_CHECK_END;
                end
            end
            S_CHECK_END: state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if ((state != S_IDLE) && ctl.abort) begin
            abort_run = 1'b1;
            state_nxt = S_IDLE;
        end
    end

    // Pattern index and sweep counter; pat wraps 3->0 into the next sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat   <= '0;
            sweep <= '0;
        end else if (start_run) begin
            pat   <= '0;
            sweep <= '0;
        end else if (sample) begin
            pat <= pat + 2'd1;
            if (pat == LAST_PAT) sweep <= sweep + 8'd1;
        end
    end

    // Registered gate stimulus; parked at 0 on abort, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= 1'b0;
            b_out <= 1'b0;
        end else if (abort_run) begin
            a_out <= 1'b0;
            b_out <= 1'b0;
        end else if (state == S_APPLY) begin
            a_out <= pat[1];
            b_out <= pat[0];
        end
    end

    // Result registers: cleared on start, accumulated on each sample, kept on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_mask_q <= '0;
            err_cnt_q   <= '0;
            pass_q      <= 1'b0;
        end else if (start_run) begin
            fail_mask_q <= '0;
            err_cnt_q   <= '0;
            pass_q      <= 1'b0;
        end else if (abort_run) begin
            pass_q <= 1'b0;
        end else begin
            if (sample && mismatch) begin
                fail_mask_q[pat] <= 1'b1;
                if (err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (state == S_CHECK_END) pass_q <= (err_cnt_q == 8'd0);
        end
    end

    assign ctl.busy      = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK_END);
    assign ctl.done      = (state == S_DONE);
    assign ctl.pass      = pass_q;
    assign ctl.fail_mask = fail_mask_q;
    assign ctl.err_cnt   = err_cnt_q;

endmodule
